hazard_ctrl: RTL

Parametrised pipeline hazard controller for the multi-stage MIPS datapath, sitting beside the register file and the pipeline latches. It decides operand forwarding for an arbitrary number of downstream result stages, with operands A and B resolved independently. It also owns stage enables and flushes for load-use bubbles (configurable load latency), memory-wait freezes and taken-branch squashes. A small state machine holds any flush that arrives during a freeze and applies it on release.

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 59 +++++
 rtl/hazard_ctrl_fwd_select.sv | 37 +++
 rtl/hazard_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module     : hazard_ctrl_pkg
// Description: Shared types for the pipeline hazard controller: register
//              select type, controller state encoding, stall-count type and
//              a saturating increment helper for the performance counters.
// Revision   : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int REGBITS = 5;
    typedef logic [REGBITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hazard_state_t;

    // Wide enough for a load latency of up to 7 bubble cycles.
    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] lucnt_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module     : hazard_ctrl_if
// Description: Bundle of pipeline status inputs and control outputs for
//              hazard_ctrl. The master side drives the EX/ID register selects,
//              forwarding-stage write info and memory/branch strobes; the
//              slave side (the controller) returns forwarding selects, latch
//              enables, flushes and performance counters.
// Revision   : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2
);
    localparam int FWD_W = $clog2(NUM_FWD + 1);

    logic [REG_W-1:0]         ex_rs;
    logic [REG_W-1:0]         ex_rt;
    logic [REG_W-1:0]         id_rs;
    logic [REG_W-1:0]         id_rt;
    logic                     id_uses_rt;
    logic                     ex_memread;
    logic [REG_W-1:0]         ex_wsel;
    logic [NUM_FWD-1:0]       fwd_regwrite;
    logic [NUM_FWD*REG_W-1:0] fwd_wsel;
    logic                     ihit;
    logic                     dhit;
    logic                     dmem_req;
    logic                     branch_taken;

    logic [FWD_W-1:0]         fwd_a;
    logic [FWD_W-1:0]         fwd_b;
    logic                     pc_en;
    logic                     ifid_en;
    logic                     idex_en;
    logic                     exmem_en;
    logic                     memwb_en;
    logic                     ifid_flush;
    logic                     idex_flush;
    logic                     exmem_flush;
    logic [31:0]              stall_cnt;
    logic [31:0]              flush_cnt;

    modport master (
        output ex_rs, ex_rt, id_rs, id_rt, id_uses_rt, ex_memread, ex_wsel,
               fwd_regwrite, fwd_wsel, ihit, dhit, dmem_req, branch_taken,
        input  fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  ex_rs, ex_rt, id_rs, id_rt, id_uses_rt, ex_memread, ex_wsel,
               fwd_regwrite, fwd_wsel, ihit, dhit, dmem_req, branch_taken,
        output fwd_a, fwd_b, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module     : hazard_ctrl_fwd_select
// Description: Operand forwarding selector. Returns the index of the nearest
//              result stage that writes the requested register.
// Ports      : sel_i      - operand register select
//              regwrite_i - per-stage write enable
//              wsel_i     - per-stage destination, slice k is stage k
//              idx_o      - 0 = register file, k = stage k-1
// Revision   : 1.0 - initial release
// ============================================================================
module hazard_ctrl_fwd_select #(
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 2,
    parameter int FWD_W   = 2
) (
    input  wire logic [REG_W-1:0]         sel_i,
    input  wire logic [NUM_FWD-1:0]       regwrite_i,
    input  wire logic [NUM_FWD*REG_W-1:0] wsel_i,
    output logic      [FWD_W-1:0]         idx_o
);

    // Scan from the farthest stage inward so the nearest match overwrites
    // any older one and ends up as the result.
    always_comb begin
        idx_o = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (regwrite_i[k] &&
                (wsel_i[k*REG_W +: REG_W] != '0) &&
                (wsel_i[k*REG_W +: REG_W] == sel_i)) begin
                idx_o = FWD_W'(k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : hazard_ctrl
// Description: Pipeline hazard controller. Resolves A/B operand forwarding
//              across NUM_FWD result stages and drives latch enables and
//              flushes for load-use bubbles (LOAD_LAT cycles), memory-wait
//              freezes and taken-branch squashes. A branch seen during a
//              freeze is held and applied on the freeze release cycle.
// Ports      : CLK, RST (synchronous, active-high)
//              hz - hazard_ctrl_if.slave bundle (selects, strobes, enables,
//                   flushes, forwarding selects, performance counters)
// Config     : HAZARD_PERF_CNT_EN - build saturating stall/flush counters;
//              when undefined both counter outputs are tied to zero.
// Revision   : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    hazard_ctrl_if.slave hz
);

    localparam int     FWD_W     = $clog2(NUM_FWD + 1);
    localparam lucnt_t LU_RELOAD = lucnt_t'(LOAD_LAT - 1);

    hazard_state_t state_q, state_d;
    lucnt_t        cnt_q, cnt_d;
    logic          pend_q, pend_d;

    logic [FWD_W-1:0] fwd_a_w, fwd_b_w;
    logic pc_en_c, ifid_en_c, back_en_c;
    logic ifid_flush_c, idex_flush_c;
    logic freeze_w, load_use_w;

    hazard_ctrl_fwd_select #(.REG_W(REG_W), .NUM_FWD(NUM_FWD), .FWD_W(FWD_W)) u_fwd_a (
        .sel_i      (hz.ex_rs),
        .regwrite_i (hz.fwd_regwrite),
        .wsel_i     (hz.fwd_wsel),
        .idx_o      (fwd_a_w)
    );

    hazard_ctrl_fwd_select #(.REG_W(REG_W), .NUM_FWD(NUM_FWD), .FWD_W(FWD_W)) u_fwd_b (
        .sel_i      (hz.ex_rt),
        .regwrite_i (hz.fwd_regwrite),
        .wsel_i     (hz.fwd_wsel),
        .idx_o      (fwd_b_w)
    );

    assign freeze_w   = hz.dmem_req && !hz.dhit;
    assign load_use_w = hz.ex_memread && (hz.ex_wsel != '0) &&
                        ((hz.ex_wsel == hz.id_rs) ||
                         (hz.id_uses_rt && (hz.ex_wsel == hz.id_rt)));

    // back_en_c covers idex/exmem/memwb, which always move together.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        back_en_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (freeze_w) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    back_en_c = 1'b0;
                    state_d   = ST_MEM_WAIT;
                end else if (hz.branch_taken) begin
                    // Squash wins over a coincident load-use stall.
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use_w) begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        cnt_d   = LU_RELOAD;
                        state_d = ST_LU_STALL;
                    end
                end else if (!hz.ihit) begin
                    pc_en_c      = 1'b0;
                    ifid_flush_c = 1'b1;
                end
            end
            ST_LU_STALL: begin
                if (freeze_w) begin
                    // Remaining bubble count is preserved across the freeze.
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    back_en_c = 1'b0;
                    state_d   = ST_MEM_WAIT;
                end else begin
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                    cnt_d        = cnt_q - lucnt_t'(1);
                    if (cnt_q == lucnt_t'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
                back_en_c = 1'b0;
                if (hz.branch_taken) begin
                    pend_d = 1'b1;
                end
                if (hz.dhit) begin
                    ifid_flush_c = pend_q;
                    idex_flush_c = pend_q;
                    pend_d       = 1'b0;
                    state_d      = (cnt_q != '0) ? ST_LU_STALL : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Reset overrides every control output so the pipe is held and drained.
    assign hz.fwd_a       = RST ? '0   : fwd_a_w;
    assign hz.fwd_b       = RST ? '0   : fwd_b_w;
    assign hz.pc_en       = RST ? 1'b0 : pc_en_c;
    assign hz.ifid_en     = RST ? 1'b0 : ifid_en_c;
    assign hz.idex_en     = RST ? 1'b0 : back_en_c;
    assign hz.exmem_en    = RST ? 1'b0 : back_en_c;
    assign hz.memwb_en    = RST ? 1'b0 : back_en_c;
    assign hz.ifid_flush  = RST ? 1'b1 : ifid_flush_c;
    assign hz.idex_flush  = RST ? 1'b1 : idex_flush_c;
    assign hz.exmem_flush = RST;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_c) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
            if (idex_flush_c) begin
                flush_cnt_q <= sat_inc32(flush_cnt_q);
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule
`default_nettype wire
